accum_32: RTL and testbench
===========================

ACCUM_32 -- requirements
Module: accum_32

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the operand-count width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1 bit: in_data, in_last and cin are valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: unsigned operand.
REQ-008 The module SHALL have port in_last, input, 1 bit: the current operand is the final one of the group.
REQ-009 The module SHALL have port cin, input, 1 bit: carry-in, added only with the first operand of a group.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the result is available.
REQ-011 The module SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-012 The module SHALL have port out_sum, output, WIDTH bits: the group sum modulo 2^WIDTH.
REQ-013 The module SHALL have port out_cout, output, 1 bit: sticky carry-out, set if any addition in the group overflowed.
REQ-014 The module SHALL have port out_count, output, CNT_W bits: operands accepted in the group, saturating.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-016 An operand handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-018 On a handshake in IDLE, the block SHALL load acc <= in_data + cin, set the carry flag to that addition's carry-out, and set count <= 1.
REQ-019 On a handshake in ACCUM, the block SHALL load acc <= acc + in_data, OR the carry-out into the carry flag, and increment count, saturating at 2^CNT_W-1; cin SHALL be ignored.
REQ-020 All additions SHALL be unsigned WIDTH-bit additions; the sum SHALL wrap modulo 2^WIDTH, with the carry-out captured in the carry flag.
REQ-021 A handshake with in_last=1 SHALL move the FSM to DONE from either IDLE or ACCUM. This covers a single-operand group from IDLE.
REQ-022 A handshake with in_last=0 SHALL move the FSM to ACCUM, or keep it in ACCUM.
REQ-023 With in_valid=0 in IDLE or ACCUM, the block SHALL hold all state.
REQ-024 out_valid SHALL be 1 only in DONE; it SHALL rise on the cycle after the in_last handshake, giving a latency of 1 clock.
REQ-025 In DONE, out_sum, out_cout and out_count SHALL stay stable until a cycle with out_ready=1.
REQ-026 On a DONE cycle with out_ready=1, the FSM SHALL return to IDLE; the next group's first operand SHALL be accepted no earlier than the following cycle.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 out_sum, out_cout and out_count SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-029 While rst_n=0, the block SHALL force the FSM to IDLE, acc=0, carry flag=0 and count=0, asynchronously and without waiting for clk.
REQ-030 While rst_n=0, the outputs SHALL be in_ready=1, out_valid=0, out_sum=0, out_cout=0 and out_count=0.
REQ-031 A reset asserted during ACCUM or DONE SHALL discard the partial or pending result; no out_valid SHALL follow.
REQ-032 The first handshake after rst_n rises SHALL be treated as the first operand of a new group.

Verification
REQ-033 Scenario 1: cin=0; operands 5000 then 10200 (last) -> out_valid one cycle after the last handshake, out_sum=15200, out_cout=0, out_count=2.
REQ-034 Scenario 2: cin=1 on the first operand; operands 5000 then 10207 (last) -> out_sum=15208, out_cout=0, out_count=2; a cin=1 presented on the second operand is verified to have no effect.
REQ-035 Scenario 3: operands 0xFFFFFFFF then 1 (last), cin=0 -> out_sum=0, out_cout=1. A follow-up group with single operand 0 (last) and cin=1 -> out_sum=1, out_cout=0 and out_count=1, confirming the sticky flag is cleared per group.
REQ-036 Scenario 4: out_ready held at 0 for 10 cycles in DONE while in_valid=1 -> in_ready=0, no operand accepted, and the outputs stable. Then out_ready=1 for 1 cycle -> IDLE on the next cycle.
REQ-037 Scenario 5: 300 operands of value 1, with last on the 300th and in_valid gaps inserted -> out_sum=300, out_count=255 (saturated), out_cout=0.
REQ-038 Scenario 6: rst_n pulsed low mid-clock after 2 of 3 operands (values 7 and 8) -> outputs zero immediately, with no out_valid. A new group of 4 (last) -> out_sum=4.

Source files
------------

// File: rtl/accum_if.sv
// Operand/result handshake bundle for the accum_32 group accumulator.
// The master drives operands and consumes results; the slave is the accumulator.
interface accum_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, in_last, cin, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, cin, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_count
   );
endinterface

// File: rtl/accum_32.sv
// Group accumulator: sums a stream of unsigned operands up to in_last, with a sticky
// carry-out and a saturating operand count, then holds the result until consumed.
module accum_32 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input logic   clk,
   input logic   rst_n,
   accum_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic             carry_reg, carry_next;
   logic [CNT_W-1:0] count_reg, count_next;

   logic             handshake;
   logic [WIDTH-1:0] add_a;
   logic             add_cin;
   logic [WIDTH:0]   add_res;

   assign handshake = bus.in_valid && (state_reg != DONE);

   // One shared adder: a group's first operand is added to zero plus cin,
   // every later operand to the running sum with cin ignored.
   assign add_a   = (state_reg == IDLE) ? '0 : acc_reg;
   assign add_cin = (state_reg == IDLE) ? bus.cin : 1'b0;
   assign add_res = {1'b0, add_a} + {1'b0, bus.in_data} + {{WIDTH{1'b0}}, add_cin};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         carry_reg <= 1'b0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         carry_reg <= carry_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      carry_next = carry_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (handshake) begin
               acc_next   = add_res[WIDTH-1:0];
               carry_next = add_res[WIDTH];
               count_next = CNT_ONE;
               state_next = bus.in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (handshake) begin
               acc_next   = add_res[WIDTH-1:0];
               carry_next = carry_reg | add_res[WIDTH];
               if (count_reg != CNT_MAX) begin
                  count_next = count_reg + CNT_ONE;
               end
               state_next = bus.in_last ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Result outputs come straight from registers; no input reaches them combinationally.
   assign bus.in_ready  = (state_reg != DONE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.out_sum   = acc_reg;
   assign bus.out_cout  = carry_reg;
   assign bus.out_count = count_reg;
endmodule

// File: tb/tb_accum_32.sv
// Self-checking bench for accum_32: table-driven groups, randomized groups against a
// plain-arithmetic reference, and hand-written backpressure / saturation / reset sequences.
module tb_accum_32;
   logic clk;
   logic rst_n;

   accum_if #(.WIDTH(32), .CNT_W(8)) bus ();

   accum_32 #(.WIDTH(32), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] op_q[$];

   typedef struct packed {
      logic            cin_first;
      logic            cin_rest;
      logic [2:0]      n;
      logic [3:0][31:0] ops;
      logic [31:0]     exp_sum;
      logic            exp_cout;
      logic [7:0]      exp_cnt;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; returns just after a falling edge with the result drained.
   task automatic run_group(input string name, input logic cf, input logic cr, input int gap_pct,
                            input logic [31:0] es, input logic ec, input logic [7:0] en);
      int n;
      n = op_q.size();
      for (int i = 0; i < n; i++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
            bus.cin      = 1'b1;
            @(negedge clk);
         end
         if (bus.in_ready !== 1'b1) check({name, " in_ready before op"}, 64'(bus.in_ready), 64'd1);
         bus.in_valid = 1'b1;
         bus.in_data  = op_q[i];
         bus.in_last  = (i == n - 1);
         bus.cin      = (i == 0) ? cf : cr;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.cin      = 1'b0;
      check({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, " out_sum"},   64'(bus.out_sum),   64'(es));
      check({name, " out_cout"},  64'(bus.out_cout),  64'(ec));
      check({name, " out_count"}, 64'(bus.out_count), 64'(en));
      $display("group %s: ops=%0d sum=%0h cout=%0b count=%0d (exp %0h/%0b/%0d)",
               name, n, bus.out_sum, bus.out_cout, bus.out_count, es, ec, en);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({name, " drained out_valid"}, 64'(bus.out_valid), 64'd0);
      check({name, " drained in_ready"},  64'(bus.in_ready),  64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      longint      total;
      int          n;
      logic        c;
      logic [31:0] v;

      vecs[0] = '{cin_first: 1'b0, cin_rest: 1'b0, n: 3'd2, ops: {32'd0, 32'd0, 32'd10200, 32'd5000},
                  exp_sum: 32'd15200, exp_cout: 1'b0, exp_cnt: 8'd2};
      vecs[1] = '{cin_first: 1'b1, cin_rest: 1'b1, n: 3'd2, ops: {32'd0, 32'd0, 32'd10207, 32'd5000},
                  exp_sum: 32'd15208, exp_cout: 1'b0, exp_cnt: 8'd2};
      vecs[2] = '{cin_first: 1'b0, cin_rest: 1'b0, n: 3'd2, ops: {32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF},
                  exp_sum: 32'd0, exp_cout: 1'b1, exp_cnt: 8'd2};
      vecs[3] = '{cin_first: 1'b1, cin_rest: 1'b0, n: 3'd1, ops: {32'd0, 32'd0, 32'd0, 32'd0},
                  exp_sum: 32'd1, exp_cout: 1'b0, exp_cnt: 8'd1};
      vecs[4] = '{cin_first: 1'b0, cin_rest: 1'b0, n: 3'd3,
                  ops: {32'd0, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  exp_sum: 32'd0, exp_cout: 1'b1, exp_cnt: 8'd3};
      vecs[5] = '{cin_first: 1'b1, cin_rest: 1'b1, n: 3'd4,
                  ops: {32'd0, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000},
                  exp_sum: 32'd0, exp_cout: 1'b1, exp_cnt: 8'd4};
      vecs[6] = '{cin_first: 1'b1, cin_rest: 1'b0, n: 3'd1, ops: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF},
                  exp_sum: 32'd0, exp_cout: 1'b1, exp_cnt: 8'd1};
      vecs[7] = '{cin_first: 1'b0, cin_rest: 1'b1, n: 3'd3, ops: {32'd0, 32'd3, 32'd2, 32'd1},
                  exp_sum: 32'd6, exp_cout: 1'b0, exp_cnt: 8'd3};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check("reset in_ready",  64'(bus.in_ready),  64'd1);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset out_sum",   64'(bus.out_sum),   64'd0);
      check("reset out_cout",  64'(bus.out_cout),  64'd0);
      check("reset out_count", 64'(bus.out_count), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-reset out_valid", 64'(bus.out_valid), 64'd0);

      // Table-driven groups
      for (int i = 0; i < 8; i++) begin
         op_q.delete();
         for (int j = 0; j < int'(vecs[i].n); j++) op_q.push_back(vecs[i].ops[j]);
         run_group($sformatf("vec%0d", i), vecs[i].cin_first, vecs[i].cin_rest, 0,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_cnt);
      end

      // Randomized groups: sum is total mod 2^32; any per-step wrap happens iff total >= 2^32
      for (int g = 0; g < 25; g++) begin
         op_q.delete();
         n = $urandom_range(1, 6);
         c = 1'($urandom_range(0, 1));
         total = longint'(c);
         for (int j = 0; j < n; j++) begin
            v = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
            op_q.push_back(v);
            total += longint'(v);
         end
         run_group($sformatf("rand%0d", g), c, 1'($urandom_range(0, 1)), 30,
                   total[31:0], (total >= 64'h1_0000_0000), 8'((n > 255) ? 255 : n));
      end

      // Backpressure: DONE held for 10 cycles with an operand waiting
      bus.in_valid = 1'b1; bus.in_data = 32'd10; bus.in_last = 1'b0; bus.cin = 1'b0;
      @(negedge clk);
      bus.in_data = 32'd20; bus.in_last = 1'b1;
      @(negedge clk);
      bus.in_data = 32'd999; bus.in_last = 1'b1; bus.cin = 1'b1;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("hold%0d in_ready", k),  64'(bus.in_ready),  64'd0);
         check($sformatf("hold%0d out_valid", k), 64'(bus.out_valid), 64'd1);
         check($sformatf("hold%0d out_sum", k),   64'(bus.out_sum),   64'd30);
         check($sformatf("hold%0d out_count", k), 64'(bus.out_count), 64'd2);
         @(negedge clk);
      end
      $display("group hold: sum=%0d count=%0d held 10 cycles", bus.out_sum, bus.out_count);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("hold release out_valid", 64'(bus.out_valid), 64'd0);
      check("hold release in_ready",  64'(bus.in_ready),  64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.cin = 1'b0;
      check("after hold out_valid", 64'(bus.out_valid), 64'd1);
      check("after hold out_sum",   64'(bus.out_sum),   64'd1000);
      check("after hold out_count", 64'(bus.out_count), 64'd1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // Saturating count: 300 ones with gaps
      op_q.delete();
      for (int j = 0; j < 300; j++) op_q.push_back(32'd1);
      run_group("sat300", 1'b0, 1'b0, 25, 32'd300, 1'b0, 8'd255);

      // Asynchronous reset in the middle of a group
      bus.in_valid = 1'b1; bus.in_data = 32'd7; bus.in_last = 1'b0; bus.cin = 1'b0;
      @(negedge clk);
      bus.in_data = 32'd8;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("pre-reset out_sum", 64'(bus.out_sum), 64'd15);
      #2 rst_n = 1'b0;
      #1;
      check("midreset out_sum",   64'(bus.out_sum),   64'd0);
      check("midreset out_count", 64'(bus.out_count), 64'd0);
      check("midreset out_cout",  64'(bus.out_cout),  64'd0);
      check("midreset out_valid", 64'(bus.out_valid), 64'd0);
      check("midreset in_ready",  64'(bus.in_ready),  64'd1);
      $display("group midreset: outputs sum=%0d count=%0d after async reset", bus.out_sum, bus.out_count);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post-midreset%0d out_valid", k), 64'(bus.out_valid), 64'd0);
      end
      op_q.delete();
      op_q.push_back(32'd4);
      run_group("after_reset", 1'b0, 1'b0, 0, 32'd4, 1'b0, 8'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
